spu_regfile_wb: RTL and testbench
=================================

// Module: spu_regfile_wb
// PURPOSE
// - Writeback end of the SPU execute pipes: accepts rt_wb/rt_addr_wb/reg_write_wb from even and odd pipes.
// - Commits them into the 128 x 128-bit register file.
// - Serves the three RF-stage source operands (ra/rb/rc), with write-to-read bypass.
// - Keeps a per-register pending-write scoreboard, so issue stalls on RAW hazards against in-flight results.
// PARAMETERS
// - NUM_REGS  128  register count (addresses 0..127, no hardwired register)
// - WIDTH     128  register width, bit 0 = MSB
// - ADDR_W    7    register address width
// - PEND_W    3    per-register pending-write counter width (max 7 in flight)
// PORTS
// - clk          in   1       clock, all state updates on posedge
// - reset        in   1       synchronous, active-low (0 = reset)
// - wb_e_data    in   WIDTH   even-pipe result (rt_wb)
// - wb_e_addr    in   ADDR_W  even-pipe destination (rt_addr_wb)
// - wb_e_we      in   1       even-pipe write enable (reg_write_wb)
// - wb_o_data    in   WIDTH   odd-pipe result
// - wb_o_addr    in   ADDR_W  odd-pipe destination
// - wb_o_we      in   1       odd-pipe write enable
// - ra_addr/rb_addr/rc_addr  in  ADDR_W  RF-stage source addresses
// - ra/rb/rc     out  WIDTH   source operand values, registered
// - issue_valid  in   1       instruction presented for issue this cycle
// - issue_rt     in   ADDR_W  its destination address
// - issue_wr     in   1       it writes issue_rt
// - src_used     in   3       {ra,rb,rc} used by the issuing instruction
// - stall        out  1       combinational; issue refused this cycle
// - wb_conflict  out  1       registered one-cycle pulse: both pipes wrote the same address
// - pend_err     out  1       sticky: writeback to a register with pending count 0
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - all registers 0, all pending counters 0;
//   - ra/rb/rc 0, wb_conflict 0, pend_err 0;
//   - applies mid-operation; writebacks and issues in that cycle are dropped.
// - Write: at posedge, wb_X_we=1 writes wb_X_data into reg[wb_X_addr].
//   - Both ports, same address: even data is committed; wb_conflict=1 the following cycle.
// - Read (latency 1): ra <= reg[ra_addr], likewise rb/rc.
//   - Bypass: if a port writes that address in the same cycle, the output takes the new data (even wins on conflict).
// - Scoreboard: pend[r] is a PEND_W-bit count of in-flight writes to r.
//   - +1 on accepted issue (issue_valid & issue_wr & !stall) to issue_rt.
//   - -1 per writeback port with we=1 to r (both ports, same r: -2).
//   - Increment and decrement on the same r in one cycle: net sum applied.
//   - Decrement below 0: clamps at 0 and sets pend_err (cleared only by reset).
// - stall = issue_valid & (hazard_a | hazard_b | hazard_c | full).
//   - hazard_a = src_used[2] & pend[ra_addr]!=0; b and c likewise.
//   - full = issue_wr & pend[issue_rt]==max.
//   - Stall uses current pend only; no early release from same-cycle writeback.
// - A stalled issue changes no state. The issuer holds its inputs until stall=0.
// TESTING
// - Reset with wb_e_we=1 and issue_valid=1 -> next cycle ra=rb=rc=0, pend all 0, no write committed.
// - Write sequence:
//   - Write r5=0x1234..(128b) on even; next cycle ra_addr=5 -> ra=0x1234.. one cycle later.
//   - Same-cycle write r9=0xAA.. with ra_addr=9 -> ra=0xAA.. (bypass).
// - Conflict: even writes r3=1, odd writes r3=2 in the same cycle -> r3=1, wb_conflict pulses 1 cycle.
// - Hazard:
//   - Issue rt=7 -> pend[7]=1.
//   - Issue with ra_addr=7, src_used=3'b100 -> stall=1.
//   - Writeback r7 -> next cycle stall=0 and issue is accepted.
// - Saturation: 7 issues to r12 without writeback -> 8th issue stall=1; one writeback to r12 -> issue accepted, pend[12]=7.
// - Writeback to r20 with pend[20]=0 -> r20 written, pend stays 0, pend_err=1 until reset.

Source files
------------

// File: rtl/spu_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : spu_regfile_wb
// Purpose  : SPU writeback register file with operand bypass and RAW scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module spu_regfile_wb #(
    parameter int NUM_REGS = 128,
    parameter int WIDTH    = 128,
    parameter int ADDR_W   = 7,
    parameter int PEND_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:WIDTH-1]  wb_e_data,
    input  logic [ADDR_W-1:0] wb_e_addr,
    input  logic              wb_e_we,
    input  logic [0:WIDTH-1]  wb_o_data,
    input  logic [ADDR_W-1:0] wb_o_addr,
    input  logic              wb_o_we,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] rc_addr,
    output logic [0:WIDTH-1]  ra,
    output logic [0:WIDTH-1]  rb,
    output logic [0:WIDTH-1]  rc,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic              issue_wr,
    input  logic [2:0]        src_used,
    output logic              stall,
    output logic              wb_conflict,
    output logic              pend_err
);

    localparam logic [PEND_W-1:0] C_PEND_MAX = '1;

    logic [0:WIDTH-1]  rf_q   [NUM_REGS];
    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic [0:WIDTH-1]  ra_q, rb_q, rc_q;
    logic [0:WIDTH-1]  ra_d, rb_d, rc_d;
    logic              wb_conflict_q, pend_err_q, pend_err_d;
    logic              w_hz_a, w_hz_b, w_hz_c, w_full, w_issue_acc, w_conflict;
    logic [PEND_W:0]   w_up, w_dec, w_net;

    // Stall looks only at the current counts; a same-cycle writeback does not release it.
    always_comb begin
        w_hz_a      = src_used[2] && (pend_q[ra_addr] != '0);
        w_hz_b      = src_used[1] && (pend_q[rb_addr] != '0);
        w_hz_c      = src_used[0] && (pend_q[rc_addr] != '0);
        w_full      = issue_wr && (pend_q[issue_rt] == C_PEND_MAX);
        stall       = issue_valid && (w_hz_a || w_hz_b || w_hz_c || w_full);
        w_issue_acc = issue_valid && issue_wr && !stall;
        w_conflict  = wb_e_we && wb_o_we && (wb_e_addr == wb_o_addr);
    end

    // Odd is applied first so even overrides it on an address collision.
    always_comb begin
        ra_d = rf_q[ra_addr];
        rb_d = rf_q[rb_addr];
        rc_d = rf_q[rc_addr];
        if (wb_o_we && wb_o_addr == ra_addr) ra_d = wb_o_data;
        if (wb_o_we && wb_o_addr == rb_addr) rb_d = wb_o_data;
        if (wb_o_we && wb_o_addr == rc_addr) rc_d = wb_o_data;
        if (wb_e_we && wb_e_addr == ra_addr) ra_d = wb_e_data;
        if (wb_e_we && wb_e_addr == rb_addr) rb_d = wb_e_data;
        if (wb_e_we && wb_e_addr == rc_addr) rc_d = wb_e_data;
    end

    always_comb begin
        pend_err_d = pend_err_q;
        w_up       = '0;
        w_dec      = '0;
        w_net      = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_up  = {1'b0, pend_q[r]} + (PEND_W+1)'(w_issue_acc && (issue_rt == ADDR_W'(r)));
            w_dec = (PEND_W+1)'(wb_e_we && (wb_e_addr == ADDR_W'(r)))
                  + (PEND_W+1)'(wb_o_we && (wb_o_addr == ADDR_W'(r)));
            if (w_up < w_dec) begin
                pend_d[r]  = '0;
                pend_err_d = 1'b1;
            end else begin
                w_net     = w_up - w_dec;
                pend_d[r] = w_net[PEND_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf_q[r]   <= '0;
                pend_q[r] <= '0;
            end
            ra_q          <= '0;
            rb_q          <= '0;
            rc_q          <= '0;
            wb_conflict_q <= 1'b0;
            pend_err_q    <= 1'b0;
        end else begin
            if (wb_o_we) rf_q[wb_o_addr] <= wb_o_data;
            if (wb_e_we) rf_q[wb_e_addr] <= wb_e_data;
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            rc_q          <= rc_d;
            wb_conflict_q <= w_conflict;
            pend_err_q    <= pend_err_d;
        end
    end

    assign ra          = ra_q;
    assign rb          = rb_q;
    assign rc          = rc_q;
    assign wb_conflict = wb_conflict_q;
    assign pend_err    = pend_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_regfile_wb
// Purpose  : Directed and randomized checks of spu_regfile_wb against a model
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu_regfile_wb;

    localparam int W = 128;
    localparam int A = 7;
    localparam int N = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:W-1] wb_e_data, wb_o_data;
    logic [A-1:0] wb_e_addr, wb_o_addr, ra_addr, rb_addr, rc_addr, issue_rt;
    logic         wb_e_we, wb_o_we, issue_valid, issue_wr;
    logic [2:0]   src_used;
    logic [0:W-1] ra, rb, rc;
    logic         stall, wb_conflict, pend_err;

    logic [0:W-1] m_rf   [N];
    int           m_pend [N];
    bit           m_err;
    int           n_chk, n_fail;
    logic         s;
    logic [0:W-1] c_val;

    always #5 clk = ~clk;

    spu_regfile_wb dut (
        .clk(clk), .reset(reset),
        .wb_e_data(wb_e_data), .wb_e_addr(wb_e_addr), .wb_e_we(wb_e_we),
        .wb_o_data(wb_o_data), .wb_o_addr(wb_o_addr), .wb_o_we(wb_o_we),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .ra(ra), .rb(rb), .rc(rc),
        .issue_valid(issue_valid), .issue_rt(issue_rt), .issue_wr(issue_wr),
        .src_used(src_used), .stall(stall),
        .wb_conflict(wb_conflict), .pend_err(pend_err)
    );

    task automatic check_val(input string tag, input logic [0:W-1] got, input logic [0:W-1] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [0:W-1] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Value a read port should see: newest write this cycle, even over odd.
    function automatic logic [0:W-1] model_read(input logic [A-1:0] a);
        if (wb_e_we && wb_e_addr == a) return wb_e_data;
        if (wb_o_we && wb_o_addr == a) return wb_o_data;
        return m_rf[a];
    endfunction

    task automatic idle();
        reset       = 1'b1;
        wb_e_we     = 1'b0; wb_e_addr = '0; wb_e_data = '0;
        wb_o_we     = 1'b0; wb_o_addr = '0; wb_o_data = '0;
        ra_addr     = '0;   rb_addr   = '0; rc_addr   = '0;
        issue_valid = 1'b0; issue_wr  = 1'b0; issue_rt = '0;
        src_used    = '0;
    endtask

    // One clock: check stall, advance the model, check registered outputs.
    task automatic step(output logic obs_stall);
        bit           exp_stall, exp_conf;
        logic [0:W-1] exp_a, exp_b, exp_c;
        int           np;
        #1;
        exp_stall = issue_valid && ((src_used[2] && m_pend[ra_addr] != 0) ||
                                    (src_used[1] && m_pend[rb_addr] != 0) ||
                                    (src_used[0] && m_pend[rc_addr] != 0) ||
                                    (issue_wr && m_pend[issue_rt] == 7));
        obs_stall = stall;
        check_val("stall", stall, exp_stall);
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                m_rf[r] = '0; m_pend[r] = 0;
            end
            m_err = 0; exp_a = '0; exp_b = '0; exp_c = '0; exp_conf = 0;
        end else begin
            exp_a    = model_read(ra_addr);
            exp_b    = model_read(rb_addr);
            exp_c    = model_read(rc_addr);
            exp_conf = wb_e_we && wb_o_we && (wb_e_addr == wb_o_addr);
            for (int r = 0; r < N; r++) begin
                np = m_pend[r];
                if (issue_valid && issue_wr && !exp_stall && issue_rt == r) np++;
                if (wb_e_we && wb_e_addr == r) np--;
                if (wb_o_we && wb_o_addr == r) np--;
                if (np < 0) begin np = 0; m_err = 1; end
                m_pend[r] = np;
            end
            if (wb_o_we) m_rf[wb_o_addr] = wb_o_data;
            if (wb_e_we) m_rf[wb_e_addr] = wb_e_data;
        end
        @(posedge clk);
        #1;
        check_val("ra", ra, exp_a);
        check_val("rb", rb, exp_b);
        check_val("rc", rc, exp_c);
        check_val("wb_conflict", wb_conflict, exp_conf);
        check_val("pend_err", pend_err, m_err);
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_err = 0;
        for (int r = 0; r < N; r++) begin m_rf[r] = '0; m_pend[r] = 0; end
        idle();
        @(negedge clk);
        reset = 1'b0;
        step(s);

        // Reset while a writeback and an issue are presented
        idle(); reset = 1'b0;
        wb_e_we = 1'b1; wb_e_addr = 7'd1; wb_e_data = '1;
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rt = 7'd2;
        step(s);
        idle(); ra_addr = 7'd1; rb_addr = 7'd2; issue_valid = 1'b1; src_used = 3'b010;
        step(s);
        check_val("rst_no_write", ra, '0);
        check_val("rst_pend_clear", s, 1'b0);

        // Plain write then read
        c_val = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        idle(); wb_e_we = 1'b1; wb_e_addr = 7'd5; wb_e_data = c_val;
        step(s);
        idle(); ra_addr = 7'd5;
        step(s);
        check_val("r5_read", ra, c_val);

        // Same-cycle bypass
        c_val = {16{8'hAA}};
        idle(); wb_e_we = 1'b1; wb_e_addr = 7'd9; wb_e_data = c_val; ra_addr = 7'd9;
        step(s);
        check_val("r9_bypass", ra, c_val);

        // Dual-port conflict
        idle();
        wb_e_we = 1'b1; wb_e_addr = 7'd3; wb_e_data = 128'd1;
        wb_o_we = 1'b1; wb_o_addr = 7'd3; wb_o_data = 128'd2;
        step(s);
        check_val("conflict_pulse", wb_conflict, 1'b1);
        idle(); rc_addr = 7'd3;
        step(s);
        check_val("conflict_even_wins", rc, 128'd1);
        check_val("conflict_one_cycle", wb_conflict, 1'b0);

        // RAW hazard
        idle(); issue_valid = 1'b1; issue_wr = 1'b1; issue_rt = 7'd7;
        step(s);
        check_val("hz_issue_rt7", s, 1'b0);
        idle(); issue_valid = 1'b1; issue_wr = 1'b1; issue_rt = 7'd8;
        ra_addr = 7'd7; src_used = 3'b100;
        step(s);
        check_val("hz_stall", s, 1'b1);
        wb_o_we = 1'b1; wb_o_addr = 7'd7; wb_o_data = rnd_data();
        step(s);
        check_val("hz_no_early_release", s, 1'b1);
        wb_o_we = 1'b0;
        step(s);
        check_val("hz_released", s, 1'b0);

        // Counter saturation
        idle(); issue_valid = 1'b1; issue_wr = 1'b1; issue_rt = 7'd12;
        for (int i = 0; i < 7; i++) begin
            step(s);
            check_val("sat_accept", s, 1'b0);
        end
        step(s);
        check_val("sat_full", s, 1'b1);
        wb_e_we = 1'b1; wb_e_addr = 7'd12; wb_e_data = rnd_data();
        step(s);
        check_val("sat_full_same_cycle", s, 1'b1);
        wb_e_we = 1'b0;
        step(s);
        check_val("sat_after_wb", s, 1'b0);
        step(s);
        check_val("sat_back_to_7", s, 1'b1);

        // Underflow error, sticky until reset
        idle(); reset = 1'b0;
        step(s);
        idle();
        step(s);
        check_val("err_clear", pend_err, 1'b0);
        c_val = rnd_data();
        wb_e_we = 1'b1; wb_e_addr = 7'd20; wb_e_data = c_val;
        step(s);
        check_val("err_set", pend_err, 1'b1);
        idle(); ra_addr = 7'd20; issue_valid = 1'b1; src_used = 3'b100;
        step(s);
        check_val("err_r20_written", ra, c_val);
        check_val("err_r20_pend0", s, 1'b0);
        check_val("err_sticky", pend_err, 1'b1);
        idle(); reset = 1'b0;
        step(s);
        check_val("err_reset", pend_err, 1'b0);

        // Randomized traffic on a small address window to provoke collisions
        for (int i = 0; i < 800; i++) begin
            idle();
            reset       = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            wb_e_we     = $urandom_range(0, 1) == 1;
            wb_e_addr   = A'($urandom_range(0, 15));
            wb_e_data   = rnd_data();
            wb_o_we     = $urandom_range(0, 1) == 1;
            wb_o_addr   = A'($urandom_range(0, 15));
            wb_o_data   = rnd_data();
            ra_addr     = A'($urandom_range(0, 15));
            rb_addr     = A'($urandom_range(0, 15));
            rc_addr     = A'($urandom_range(0, 15));
            issue_valid = $urandom_range(0, 9) < 7;
            issue_wr    = $urandom_range(0, 3) != 0;
            issue_rt    = A'($urandom_range(0, 15));
            src_used    = 3'($urandom_range(0, 7));
            step(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
